fetch_pair_unit: RTL

//  Dual-issue instruction fetch stage: the reader side of the instruction ROM.

---
 rtl/fetch_pair_unit_if.sv | 36 +++
 rtl/fetch_pair_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_pair_unit_if.sv
// Fetch-unit bus bundle: the ROM read port and the decode-side pair handshake.
//   rom_addr        word address presented to the instruction ROM
//   rom_instr1/2    ROM words at rom_addr and rom_addr+1, one cycle after the address
//   out_valid       a pair is presented to decode
//   out_ready       decode accepts the presented pair
//   out_pc          PC of out_instr1 (out_instr2 sits at out_pc+4)
//   out_instr1/2    the instruction pair (NOP when not valid)
//   out_slot2_valid slot 2 holds a usable instruction
// master: the fetch unit. slave: the ROM plus decode side.
interface fetch_pair_unit_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr1;
  logic [31:0]       rom_instr2;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr1;
  logic [31:0]       out_instr2;
  logic              out_slot2_valid;

  modport master (
    output rom_addr,
    input  rom_instr1, rom_instr2,
    output out_valid, out_pc, out_instr1, out_instr2, out_slot2_valid,
    input  out_ready
  );

  modport slave (
    input  rom_addr,
    output rom_instr1, rom_instr2,
    input  out_valid, out_pc, out_instr1, out_instr2, out_slot2_valid,
    output out_ready
  );
endinterface

// File: rtl/fetch_pair_unit.sv
// Dual-issue instruction fetch stage. Drives the ROM word address from the PC, captures the
// two-word pair returned one cycle later and queues it in a small FIFO for decode.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   bus             fetch_pair_unit_if.master (ROM port + decode handshake)
//   redirect_valid  1-cycle pulse: flush everything and restart fetch at redirect_pc
//   redirect_pc     new PC, bits [1:0] ignored
//   fifo_count      current pair-FIFO occupancy
module fetch_pair_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  fetch_pair_unit_if.master             bus,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [31:0]     Nop      = 32'h0000_0013;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [OccW-1:0] DepthOcc = OccW'(FIFO_DEPTH);

  logic [31:0]     pc_q, req_pc_q;
  logic            inflight_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [31:0] mem_pc_q [FIFO_DEPTH];
  logic [31:0] mem_i1_q [FIFO_DEPTH];
  logic [31:0] mem_i2_q [FIFO_DEPTH];
  logic        mem_s2_q [FIFO_DEPTH];

  logic            head_valid, pop_req, pop, push, issue, slot2_ok;
  logic [OccW-1:0] occupancy;

  assign bus.rom_addr = pc_q[ADDR_W+1:2];

  assign head_valid = (count_q != '0);
  assign pop_req    = head_valid & bus.out_ready;
  // Redirect squashes the head, so a pop offered in that cycle is dropped.
  assign pop        = pop_req & ~redirect_valid;
  assign push       = inflight_q & ~redirect_valid;

  // Credit check: entries left after this cycle's pop plus the pair already in flight must
  // leave room for the pair issued now, so a push never meets a full FIFO.
  assign occupancy = OccW'(count_q) - OccW'(pop_req) + OccW'(inflight_q);
  assign issue     = ~redirect_valid & (occupancy < DepthOcc);

  // The last ROM word has no successor; instr2 there is a wrapped read of word 0.
  assign slot2_ok = (req_pc_q[ADDR_W+1:2] != '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + 32'd8;
        req_pc_q <= pc_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_pc_q[wr_ptr_q] <= req_pc_q;
      mem_i1_q[wr_ptr_q] <= bus.rom_instr1;
      mem_i2_q[wr_ptr_q] <= bus.rom_instr2;
      mem_s2_q[wr_ptr_q] <= slot2_ok;
    end
  end

  always_comb begin
    bus.out_valid       = head_valid;
    bus.out_pc          = '0;
    bus.out_instr1      = Nop;
    bus.out_instr2      = Nop;
    bus.out_slot2_valid = 1'b0;
    if (head_valid) begin
      bus.out_pc          = mem_pc_q[rd_ptr_q];
      bus.out_instr1      = mem_i1_q[rd_ptr_q];
      bus.out_slot2_valid = mem_s2_q[rd_ptr_q];
      if (mem_s2_q[rd_ptr_q]) bus.out_instr2 = mem_i2_q[rd_ptr_q];
    end
  end

  assign fifo_count = count_q;

  push_never_full: assert property (@(posedge clk) disable iff (rst) push |-> count_q != DepthCnt);

endmodule
